dmem_arbiter: RTL and testbench

- Shared data-memory arbiter sitting directly downstream of the cores' data-memory ports (address, write data, read/write strobes).
- Serialises one access at a time from NCORES requesters onto a single-port synchronous data memory with fixed read latency.
- Returns read data and a one-cycle acknowledge to the winning core.
- Fairness: round-robin, so no core starves.

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises NCORES data-memory requesters onto one
// single-port synchronous memory with a fixed read latency.
module dmem_arbiter #(
  parameter int NCORES  = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_rd,
  input  logic [NCORES-1:0]    req_wr,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_wdata,
  output logic [NCORES-1:0]    ack,
  output logic [DW-1:0]        rd_data,
  output logic [NCORES-1:0]    grant,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [CW-1:0]       cnt;
  logic                op_wr;

  logic [NCORES-1:0]   req;
  logic                any_req;
  logic [PW-1:0]       win;
  logic [NCORES-1:0]   win_oh;
  logic                pick_found;
  int                  pick_idx;
  logic [PW-1:0]       pick_sel;

  assign req     = req_rd | req_wr;
  assign any_req = |req;

  // Scan upward from the core after the last winner, wrapping at NCORES.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    win        = '0;
    pick_found = 1'b0;
    pick_idx   = 0;
    pick_sel   = '0;
    for (int k = 1; k <= NCORES; k++) begin
      pick_idx = int'(rr_ptr) + k;
      if (pick_idx >= NCORES) pick_idx = pick_idx - NCORES;
      pick_sel = PW'(pick_idx);
      if (!pick_found && req[pick_sel]) begin
        pick_found = 1'b1;
        win        = pick_sel;
      end
    end
    win_oh = NCORES'(1) << win;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NCORES - 1);
      cnt       <= '0;
      op_wr     <= 1'b0;
      ack       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            // A simultaneous read and write from one core is treated as a write.
            op_wr     <= req_wr[win];
            mem_addr  <= req_addr[win*AW +: AW];
            mem_wdata <= req_wdata[win*DW +: DW];
            rr_ptr    <= win;
            grant     <= win_oh;
            busy      <= 1'b1;
            mem_we    <= req_wr[win];
            mem_re    <= ~req_wr[win];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          if (op_wr) begin
            ack   <= grant;
            state <= DONE;
          end else begin
            cnt   <= CW'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          // mem_rdata is valid only in the last WAIT cycle.
          if (cnt == CW'(1)) begin
            rd_data <= mem_rdata;
            ack     <= grant;
            state   <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single-core transactions plus
// hand-written multi-core, fairness and mid-access reset sequences.
module tb_dmem_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req_rd, req_wr;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_wdata;
  logic [NC-1:0]     ack, grant;
  logic [DW-1:0]     rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic              busy, mem_re, mem_we;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dmem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rd_data(rd_data),
    .grant(grant), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 1K words, reloaded with a known pattern on reset; read data
  // appears LAT cycles after the mem_re cycle, junk otherwise.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] dl  [0:LAT-1];
  assign mem_rdata = dl[LAT-1];

  function automatic logic [DW-1:0] pat(input logic [9:0] a);
    return (a == 10'h040) ? 16'hBEEF : ({6'b0, a} ^ 16'hA5A5);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 1024; a++) mem[a] <= pat(10'(a));
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
    dl[0] <= mem_re ? mem[mem_addr[9:0]] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end

  typedef struct {
    logic        rd;
    logic        wr;
    int          core;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until an ack pulse shows up; lat counts cycles since the call.
  task automatic wait_ack(input string name, output logic [NC-1:0] a, output int lat);
    a   = '0;
    lat = 0;
    while (lat < 30 && a == '0) begin
      step();
      lat++;
      a = ack;
    end
    if (a == '0) check({name, "_timeout"}, 32'(a), 32'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_rd    = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_txn(input int n, input vec_t v);
    logic [NC-1:0] a;
    logic [NC-1:0] oh;
    int            lat;
    string         tag;
    tag = $sformatf("v%0d", n);
    oh  = NC'(1) << v.core;
    req_rd[v.core]                = v.rd;
    req_wr[v.core]                = v.wr;
    req_addr[v.core*AW +: AW]     = v.addr;
    req_wdata[v.core*DW +: DW]    = v.wdata;
    step();
    check({tag, "_we"},    32'(mem_we),   32'(v.wr));
    check({tag, "_re"},    32'(mem_re),   32'(v.rd & ~v.wr));
    check({tag, "_addr"},  32'(mem_addr), 32'(v.addr));
    if (v.wr) check({tag, "_wdata"}, 32'(mem_wdata), 32'(v.wdata));
    check({tag, "_grant"}, 32'(grant),    32'(oh));
    check({tag, "_busy"},  32'(busy),     32'd1);
    wait_ack(tag, a, lat);
    check({tag, "_lat"},   32'(lat + 1),  32'(v.wr ? 2 : 2 + LAT));
    check({tag, "_ack"},   32'(a),        32'(oh));
    check({tag, "_rdata"}, 32'(rd_data),  32'(v.exp_rd));
    req_rd[v.core] = 1'b0;
    req_wr[v.core] = 1'b0;
    step();
    check({tag, "_ack_off"},  32'(ack),  32'd0);
    check({tag, "_idle"},     32'(busy), 32'd0);
    check({tag, "_grant_off"}, 32'(grant), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NC-1:0] a;
    int            lat;
    int            last;
    int            ack_seen;
    vec_t          v;

    vecs[0] = '{1'b1, 1'b0, 1, 16'h0040, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 2, 16'h0100, 16'h1234, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 3, 16'h0100, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 0, 16'h0040, 16'h5A5A, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 0, 16'h0040, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b1, 2, 16'h0080, 16'h00AA, 16'h5A5A};
    vecs[6] = '{1'b1, 1'b0, 1, 16'h0080, 16'h0000, 16'h00AA};
    vecs[7] = '{1'b0, 1'b1, 3, 16'h03FF, 16'hC3C3, 16'h00AA};
    vecs[8] = '{1'b1, 1'b0, 3, 16'h03FF, 16'h0000, 16'hC3C3};

    rst = 1'b1;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    #12;
    check("rst_ack",   32'(ack),       32'd0);
    check("rst_grant", 32'(grant),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_re",    32'(mem_re),    32'd0);
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'(rd_data),   32'd0);
    do_reset();

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    // Four simultaneous reads: round-robin from core 0 after reset.
    do_reset();
    for (int i = 0; i < NC; i++) req_addr[i*AW +: AW] = 16'h0010 + 16'(i);
    req_rd = '1;
    last = 0;
    for (int k = 0; k < NC; k++) begin
      wait_ack($sformatf("rr%0d", k), a, lat);
      check($sformatf("rr%0d_ack", k),   32'(a),       32'(NC'(1) << k));
      check($sformatf("rr%0d_grant", k), 32'(grant),   32'(NC'(1) << k));
      check($sformatf("rr%0d_rdata", k), 32'(rd_data), 32'(pat(10'h010 + 10'(k))));
      if (k > 0) check($sformatf("rr%0d_gap", k), 32'(cyc - last), 32'(LAT + 3));
      last = cyc;
      req_rd[k] = 1'b0;
    end

    // Fairness: core0 keeps requesting; core3 joins after core0's first ack.
    do_reset();
    req_addr[0*AW +: AW] = 16'h0010;
    req_addr[3*AW +: AW] = 16'h0013;
    req_rd[0] = 1'b1;
    wait_ack("fair0", a, lat);
    check("fair0_ack", 32'(a), 32'b0001);
    req_rd[3] = 1'b1;
    wait_ack("fair1", a, lat);
    check("fair1_ack",   32'(a),       32'b1000);
    check("fair1_rdata", 32'(rd_data), 32'(pat(10'h013)));
    req_rd[3] = 1'b0;
    wait_ack("fair2", a, lat);
    check("fair2_ack", 32'(a), 32'b0001);
    req_rd[0] = 1'b0;
    step();

    // Reset in the middle of a read's WAIT phase.
    do_reset();
    req_addr[1*AW +: AW] = 16'h0020;
    req_rd[1] = 1'b1;
    step();
    check("abort_issue_re", 32'(mem_re), 32'd1);
    step();
    check("abort_wait_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_re",    32'(mem_re), 32'd0);
    check("abort_grant", 32'(grant),  32'd0);
    check("abort_busy",  32'(busy),   32'd0);
    check("abort_ack",   32'(ack),    32'd0);
    req_rd = '0;
    step();
    rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack != '0 || busy) ack_seen++;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);
    check("abort_rdata",  32'(rd_data),  32'd0);
    v = '{1'b1, 1'b0, 0, 16'h0030, 16'h0000, pat(10'h030)};
    run_txn(9, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
